// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from
// execute, and the instruction hand-off to decode.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic [4:0]  opcode;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_out, inst_pc, opcode,
      input  imem_valid, imem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, opcode,
      output imem_valid, imem_rdata, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry {pc, word} queue
// toward decode, redirect flush with discard of an in-flight stale response.
//
// state   | meaning
// IDLE    | no request in flight; may issue when queue has room
// WAIT    | request in flight; its response gets queued
// DISCARD | request in flight but made stale by a redirect; response dropped
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] fetch_pc;
   logic [31:0] req_addr;
   logic [31:0] fifo_pc   [2];
   logic [31:0] fifo_word [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        issue;
   logic        push;
   logic        pop;
   logic [31:0] head_word;

   // A response that lands in the same cycle as a redirect is consumed and
   // dropped, so nothing stays outstanding and the FSM returns to IDLE.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.redirect && count < 2'd2) begin
               issue      = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_valid) begin
               push       = !bus.redirect;
               state_next = IDLE;
            end else if (bus.redirect) begin
               state_next = DISCARD;
            end
         end
         DISCARD: begin
            if (bus.imem_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         issue = 1'b0;
         push  = 1'b0;
      end
   end

   assign pop       = (count != 2'd0) && bus.inst_ready && !bus.redirect && !rst;
   assign head_word = fifo_word[rd_ptr];

   assign bus.imem_req   = issue;
   assign bus.imem_addr  = fetch_pc;
   assign bus.inst_valid = (count != 2'd0) && !rst;
   assign bus.inst_out   = head_word;
   assign bus.inst_pc    = fifo_pc[rd_ptr];
   assign bus.opcode     = head_word[6:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         state <= state_next;
         if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (push)  wr_ptr   <= ~wr_ptr;
            if (pop)   rd_ptr   <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // Payload storage needs no reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (issue) req_addr <= fetch_pc;
      if (push) begin
         fifo_pc[wr_ptr]   <= req_addr;
         fifo_word[wr_ptr] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reactive memory, randomized stimulus, and a
// queue-based reference model of fetch behaviour.
module tb_instruction_fetch;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_w = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_if bus ();
   instruction_fetch_if bus_w ();

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst(rst_w), .bus(bus_w));

   int total = 0;
   int bad = 0;

   bit          drv_rst = 1'b1;
   bit          drv_redirect = 1'b0;
   logic [31:0] drv_redirect_pc = 32'h0;
   bit          drv_ready = 1'b0;

   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = 32'h0;
   int          fixed_lat = 1;
   bit          spur_en = 1'b0;
   bit          force_valid = 1'b0;
   logic [31:0] force_rdata = 32'h0;

   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_req_addr = 32'h0;
   bit          m_busy = 1'b0;
   bit          m_drop = 1'b0;
   ent_t        m_q[$];

   logic [102:0] obs_vec, exp_vec;
   logic         obs_req, obs_valid;
   logic [31:0]  obs_addr, obs_pc, obs_word;
   logic [4:0]   obs_op;
   bit           in_valid;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0033;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic tick();
      bit          v;
      logic [31:0] d;
      ent_t        h;
      bit          exp_req, exp_valid;
      ent_t        e;
      v = 1'b0;
      d = 32'h0;
      if (force_valid) begin
         v = 1'b1; d = force_rdata; force_valid = 1'b0;
      end else if (pend) begin
         if (pend_cnt <= 1) begin v = 1'b1; d = mem_word(pend_addr); pend = 1'b0; end
         else pend_cnt--;
      end else if (spur_en && $urandom_range(0, 4) == 0) begin
         v = 1'b1; d = $urandom;
      end
      in_valid = v;
      rst = drv_rst;
      bus.imem_valid  = v;
      bus.imem_rdata  = d;
      bus.redirect    = drv_redirect;
      bus.redirect_pc = drv_redirect_pc;
      bus.inst_ready  = drv_ready;
      @(negedge clk);
      exp_req   = !drv_rst && !m_busy && m_q.size() < 2 && !drv_redirect;
      exp_valid = !drv_rst && m_q.size() != 0;
      h = exp_valid ? m_q[0] : '0;
      exp_vec = {exp_req, (exp_req ? m_pc : 32'h0), exp_valid, h.pc, h.word, h.word[6:2]};
      obs_req   = bus.imem_req;
      obs_addr  = bus.imem_addr;
      obs_valid = bus.inst_valid;
      obs_pc    = bus.inst_pc;
      obs_word  = bus.inst_out;
      obs_op    = bus.opcode;
      obs_vec = {obs_req, (obs_req ? obs_addr : 32'h0), obs_valid,
                 (obs_valid ? obs_pc : 32'h0), (obs_valid ? obs_word : 32'h0),
                 (obs_valid ? obs_op : 5'h0)};
      if (obs_req === 1'b1) begin
         pend = 1'b1;
         pend_addr = obs_addr;
         pend_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
      if (drv_rst) begin
         m_pc = 32'h0; m_busy = 1'b0; m_drop = 1'b0; m_q.delete();
      end else if (drv_redirect) begin
         m_q.delete();
         m_pc = {drv_redirect_pc[31:2], 2'b00};
         if (m_busy) begin
            if (v) begin m_busy = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
         end
      end else begin
         if (exp_valid && drv_ready) void'(m_q.pop_front());
         if (m_busy && v) begin
            if (!m_drop) begin
               e.pc = m_req_addr; e.word = mem_word(m_req_addr);
               m_q.push_back(e);
            end
            m_busy = 1'b0; m_drop = 1'b0;
         end else if (exp_req) begin
            m_req_addr = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1; m_drop = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int n);
      drv_rst = 1'b1; drv_redirect = 1'b0; pend = 1'b0; force_valid = 1'b0; spur_en = 1'b0;
      repeat (n) tick();
      drv_rst = 1'b0;
   endtask

   task automatic test_reset();
      drv_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         force_valid = 1'b1; force_rdata = $urandom;
         drv_redirect = $urandom_range(0, 1); drv_redirect_pc = $urandom;
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs_vec, exp_vec); end
      end
      drv_rst = 1'b0; drv_redirect = 1'b0;
      tick();
      total++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
         bad++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
      end
   endtask

   task automatic test_basic();
      logic [31:0] addrs[$];
      logic [31:0] pops[$];
      int first_req, first_val;
      first_req = -1; first_val = -1;
      apply_reset(2);
      fixed_lat = 1; drv_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL basic_cycle%0d got=%h want=%h", i, obs_vec, exp_vec); end
         if (obs_req === 1'b1) begin addrs.push_back(obs_addr); if (first_req < 0) first_req = i; end
         if (obs_valid === 1'b1) begin
            pops.push_back(obs_pc);
            if (first_val < 0) first_val = i;
            if (obs_pc === 32'h0) begin
               total++;
               if (obs_op !== 5'b01100) begin bad++; $display("FAIL basic_opcode got=%b want=01100", obs_op); end
            end
         end
      end
      total++;
      if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
         bad++; $display("FAIL basic_addr_seq got n=%0d want 0,4,8", addrs.size());
      end
      total++;
      if (pops.size() < 3 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8) begin
         bad++; $display("FAIL basic_pc_seq got n=%0d want 0,4,8", pops.size());
      end
      total++;
      if (first_val - first_req != 2) begin
         bad++; $display("FAIL basic_latency got=%0d want=2", first_val - first_req);
      end
   endtask

   task automatic test_backpressure();
      int nreq;
      logic [31:0] pops[$];
      logic [31:0] next_addr;
      nreq = 0; next_addr = 32'hDEAD_BEEF;
      apply_reset(2);
      fixed_lat = 1; drv_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp_fill%0d got=%h want=%h", i, obs_vec, exp_vec); end
         if (obs_req === 1'b1) nreq++;
      end
      total++;
      if (nreq != 2) begin bad++; $display("FAIL bp_req_count got=%0d want=2", nreq); end
      total++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
         bad++; $display("FAIL bp_head got valid=%b pc=%h want valid=1 pc=00000000", obs_valid, obs_pc);
      end
      drv_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL bp_drain%0d got=%h want=%h", i, obs_vec, exp_vec); end
         if (obs_valid === 1'b1) pops.push_back(obs_pc);
         if (obs_req === 1'b1 && next_addr === 32'hDEAD_BEEF) next_addr = obs_addr;
      end
      total++;
      if (pops.size() < 2 || pops[0] !== 32'h0 || pops[1] !== 32'h4) begin
         bad++; $display("FAIL bp_drain_order got n=%0d want 0,4", pops.size());
      end
      total++;
      if (next_addr !== 32'h8) begin bad++; $display("FAIL bp_resume got=%h want=00000008", next_addr); end
   endtask

   task automatic test_redirect_wait();
      logic [31:0] first_addr, first_pc;
      first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF;
      apply_reset(2);
      fixed_lat = 3; drv_ready = 1'b1;
      tick();
      drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0102;
      tick();
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL rdw_redirect got=%h want=%h", obs_vec, exp_vec); end
      drv_redirect = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL rdw_cycle%0d got=%h want=%h", i, obs_vec, exp_vec); end
         if (obs_req === 1'b1 && first_addr === 32'hDEAD_BEEF) first_addr = obs_addr;
         if (obs_valid === 1'b1 && first_pc === 32'hDEAD_BEEF) first_pc = obs_pc;
      end
      total++;
      if (first_addr !== 32'h100) begin bad++; $display("FAIL rdw_next_addr got=%h want=00000100", first_addr); end
      total++;
      if (first_pc !== 32'h100) begin bad++; $display("FAIL rdw_first_pc got=%h want=00000100", first_pc); end
   endtask

   task automatic test_redirect_collision();
      apply_reset(2);
      fixed_lat = 1; drv_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL coll_setup%0d got=%h want=%h", i, obs_vec, exp_vec); end
      end
      drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_2000; drv_ready = 1'b1;
      tick();
      total++;
      if (obs_vec !== exp_vec || in_valid !== 1'b1) begin
         bad++; $display("FAIL coll_cycle got=%h want=%h imem_valid=%b", obs_vec, exp_vec, in_valid);
      end
      drv_redirect = 1'b0;
      tick();
      total++;
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL coll_flushed got inst_valid=%b want=0", obs_valid); end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL coll_after%0d got=%h want=%h", i, obs_vec, exp_vec); end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] first_pc, first_word;
      first_pc = 32'hDEAD_BEEF; first_word = 32'h0;
      apply_reset(2);
      fixed_lat = 4; drv_ready = 1'b1;
      tick();
      tick();
      drv_rst = 1'b1;
      tick();
      tick();
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL rmw_in_reset got=%h want=%h", obs_vec, exp_vec); end
      pend = 1'b0; drv_rst = 1'b0;
      force_valid = 1'b1; force_rdata = 32'hBAD0_0013;
      tick();
      total++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
         bad++; $display("FAIL rmw_first_req got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
      end
      tick();
      total++;
      if (obs_valid !== 1'b0) begin bad++; $display("FAIL rmw_late_ignored got inst_valid=%b want=0", obs_valid); end
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL rmw_cycle%0d got=%h want=%h", i, obs_vec, exp_vec); end
         if (obs_valid === 1'b1 && first_pc === 32'hDEAD_BEEF) begin first_pc = obs_pc; first_word = obs_word; end
      end
      total++;
      if (first_pc !== 32'h0 || first_word !== mem_word(32'h0)) begin
         bad++; $display("FAIL rmw_first_inst got pc=%h word=%h want pc=00000000 word=%h", first_pc, first_word, mem_word(32'h0));
      end
   endtask

   task automatic test_wrap();
      logic [31:0] addrs[$];
      logic [31:0] first_pc, first_word;
      bit          wp;
      logic [31:0] wa;
      wp = 1'b0; wa = 32'h0; first_pc = 32'hDEAD_BEEF; first_word = 32'h0;
      rst_w = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_w = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_w.imem_valid = wp;
         bus_w.imem_rdata = mem_word(wa);
         wp = 1'b0;
         @(negedge clk);
         if (bus_w.imem_req === 1'b1) begin wp = 1'b1; wa = bus_w.imem_addr; addrs.push_back(wa); end
         if (bus_w.inst_valid === 1'b1 && first_pc === 32'hDEAD_BEEF) begin
            first_pc = bus_w.inst_pc; first_word = bus_w.inst_out;
         end
         @(posedge clk); #1;
      end
      total++;
      if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
         bad++; $display("FAIL wrap_addr_seq got n=%0d want FFFFFFFC,00000000", addrs.size());
      end
      total++;
      if (first_pc !== 32'hFFFF_FFFC || first_word !== mem_word(32'hFFFF_FFFC)) begin
         bad++; $display("FAIL wrap_first_inst got pc=%h word=%h want pc=fffffffc", first_pc, first_word);
      end
   endtask

   task automatic test_random();
      apply_reset(2);
      fixed_lat = 0; spur_en = 1'b1;
      for (int i = 0; i < 800; i++) begin
         drv_ready = ($urandom_range(0, 2) != 0);
         drv_redirect = ($urandom_range(0, 11) == 0);
         drv_redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         drv_rst = ($urandom_range(0, 149) == 0);
         if (drv_rst) pend = 1'b0;
         tick();
         total++;
         if (obs_vec !== exp_vec) begin bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, obs_vec, exp_vec); end
      end
      drv_rst = 1'b0; drv_redirect = 1'b0; spur_en = 1'b0;
   endtask

   initial begin
      bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0; bus.redirect = 1'b0;
      bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
      bus_w.imem_valid = 1'b0; bus_w.imem_rdata = 32'h0; bus_w.redirect = 1'b0;
      bus_w.redirect_pc = 32'h0; bus_w.inst_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_collision();
      test_reset_mid_wait();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address of the first fetch after reset.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-006 The block SHALL have port imem_addr  output  32  byte address of the request; valid when imem_req=1.
REQ-007 The block SHALL have port imem_valid  input  1  memory response strobe, one per request, arriving 1 or more cycles after imem_req.
REQ-008 The block SHALL have port imem_rdata  input  32  instruction word; valid when imem_valid=1.
REQ-009 The block SHALL have port redirect  input  1  taken-branch/jump pulse from execute.
REQ-010 The block SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-011 The block SHALL have port inst_valid  output  1  instruction available to decode.
REQ-012 The block SHALL have port inst_ready  input  1  decode accepts the head instruction.
REQ-013 The block SHALL have port inst_out  output  32  head instruction word.
REQ-014 The block SHALL have port inst_pc  output  32  byte address of the head instruction.
REQ-015 The block SHALL have port opcode  output  5  inst_out[6:2], the control-unit opcode input; combinational from the head.

Function
REQ-016 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, word}, a 2-bit entry count, and a state machine with states IDLE, WAIT, DISCARD.
REQ-017 In IDLE, imem_req SHALL pulse for one cycle when count + outstanding < 2: imem_addr = fetch PC, fetch PC += 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), next state WAIT.
REQ-018 In WAIT, imem_req SHALL be 0; on imem_valid, {request address, imem_rdata} SHALL be pushed and state SHALL return to IDLE; at most one request is ever outstanding.
REQ-019 In DISCARD, imem_req SHALL be 0; on imem_valid, the response SHALL be dropped and state SHALL go to IDLE.
REQ-020 imem_valid in IDLE SHALL be ignored.
REQ-021 inst_valid SHALL equal (count != 0); inst_out and inst_pc SHALL present the FIFO head.
REQ-022 A handshake (inst_valid & inst_ready) SHALL pop the head at the clock edge; a push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 inst_ready with inst_valid=0 SHALL have no effect.
REQ-024 Latency: with imem_valid returned one cycle after imem_req, inst_valid SHALL rise on the cycle after imem_valid (imem_req at cycle N, imem_valid at N+1, inst_valid at N+2).
REQ-025 On redirect: FIFO SHALL be flushed (count = 0) and fetch PC SHALL load {redirect_pc[31:2], 2'b00}; if in WAIT, state SHALL go to DISCARD, otherwise to IDLE.
REQ-026 Redirect SHALL take priority over any same-cycle push, pop or new request: no request is issued in the redirect cycle, and a same-cycle imem_valid is dropped.
REQ-027 Redirect in DISCARD SHALL reload fetch PC and remain in DISCARD.
REQ-028 The first request to the redirect target SHALL issue no earlier than the cycle after the redirect, and only from IDLE.

Reset
REQ-029 While rst=1: state SHALL be IDLE, fetch PC = RESET_PC, count = 0, imem_req = 0, inst_valid = 0; imem_valid and redirect SHALL be ignored.
REQ-030 Reset asserted with a request outstanding SHALL abandon it; a late imem_valid arriving after reset release in IDLE SHALL be ignored per REQ-020.
REQ-031 The first imem_req SHALL occur on the first cycle after rst deasserts, with imem_addr = RESET_PC.

Verification
REQ-032 Reset release, memory latency 1, inst_ready=1: imem_addr sequence 0x0, 0x4, 0x8; inst_pc follows 0x0, 0x4, 0x8 with 32'h00000033 at 0x0 -> opcode 5'b01100.
REQ-033 inst_ready=0, 4 responses available: exactly 2 requests issue, then imem_req stays 0; inst_valid=1 with head pc 0x0; on inst_ready=1 entries drain in order 0x0, 0x4, then fetch resumes at 0x8.
REQ-034 Redirect to 0x0000_0102 while WAIT, latency 3: stale response dropped; next imem_addr = 0x100; first accepted inst_pc = 0x100.
REQ-035 Redirect in the same cycle as imem_valid and a pop, FIFO holding 1 entry: count = 0 afterwards, response dropped, inst_valid = 0 the next cycle.
REQ-036 RESET_PC = 0xFFFF_FFFC: imem_addr sequence 0xFFFF_FFFC, 0x0000_0000 (wrap).
REQ-037 rst asserted mid-WAIT, imem_valid arriving 1 cycle after rst release: response ignored, inst_valid = 0, first request at RESET_PC.
